// File: rtl/seg_display_if.sv
// Front-panel display bus: value/mode/cursor in, multiplexed segment/anode drive out.
interface seg_display_if;
    logic [19:0] display_value;
    logic [3:0]  display_mode;
    logic [2:0]  cursor_in;
    logic [7:0]  seg;
    logic [7:0]  an;

    modport master (
        output display_value,
        output display_mode,
        output cursor_in,
        input  seg,
        input  an
    );

    modport slave (
        input  display_value,
        input  display_mode,
        input  cursor_in,
        output seg,
        output an
    );
endinterface

// File: rtl/seg_display_driver.sv
// 8-digit common-anode 7-segment driver: sequential binary-to-BCD conversion,
// leading-zero blanking, mode annunciator, cursor blink and digit scanning.
module seg_display_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input logic          clk,
    input logic          rst_n,
    seg_display_if.slave bus
);

    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [19:0] MaxVal = 20'd999999;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

    state_e            state_q, state_d;
    logic [19:0]       cap_value_q;
    logic [3:0]        cap_mode_q;
    logic [19:0]       bin_q;
    logic [23:0]       bcd_q;
    logic [23:0]       bcd_adj;
    logic [4:0]        shift_cnt_q;
    logic [23:0]       bcd_disp_q;
    logic [3:0]        disp_mode_q;
    logic [ScanW-1:0]  scan_cnt_q;
    logic [2:0]        scan_idx_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_on_q;
    logic [7:0]        seg_q, an_q;
    logic [7:0]        upper_nz;
    logic              cursor_act;
    logic [3:0]        nib;
    logic [7:0]        letter;
    logic [7:0]        digit_seg;

    // Top BCD bit is shifted out; it is always zero for clamped inputs.
    logic unused_bcd_msb;
    assign unused_bcd_msb = bcd_adj[23];

    function automatic logic [7:0] num_seg(input logic [3:0] n);
        case (n)
            4'd0:    num_seg = 8'hC0;
            4'd1:    num_seg = 8'hF9;
            4'd2:    num_seg = 8'hA4;
            4'd3:    num_seg = 8'hB0;
            4'd4:    num_seg = 8'h99;
            4'd5:    num_seg = 8'h92;
            4'd6:    num_seg = 8'h82;
            4'd7:    num_seg = 8'hF8;
            4'd8:    num_seg = 8'h80;
            4'd9:    num_seg = 8'h90;
            default: num_seg = 8'hFF;
        endcase
    endfunction

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Converter next state: restart whenever the input pair differs from the captured one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if ({bus.display_value, bus.display_mode} != {cap_value_q, cap_mode_q})
                          state_d = StLoad;
            StLoad:   state_d = StShift;
            StShift:  if (shift_cnt_q == 5'd19) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Double-dabble add-3 correction on every nibble >= 5.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                            : bcd_q[i*4 +: 4];
        end
    end

    // Conversion datapath; the display registers change only in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_value_q <= '0;
            cap_mode_q  <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            bcd_disp_q  <= '0;
            disp_mode_q <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    cap_value_q <= bus.display_value;
                    cap_mode_q  <= bus.display_mode;
                    bin_q       <= (bus.display_value > MaxVal) ? MaxVal : bus.display_value;
                    bcd_q       <= '0;
                    shift_cnt_q <= '0;
                end
                StShift: begin
                    bcd_q       <= {bcd_adj[22:0], bin_q[19]};
                    bin_q       <= {bin_q[18:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q + 5'd1;
                end
                StCommit: begin
                    bcd_disp_q  <= bcd_q;
                    disp_mode_q <= cap_mode_q;
                end
                default: ;
            endcase
        end
    end

    // Scan and blink timebases, both free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_idx_q <= scan_idx_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + ScanW'(1);
            end
            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BlinkW'(1);
            end
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        // upper_nz[i]: some numeric digit at position i or above is non-zero
        upper_nz = '0;
        for (int i = 5; i >= 0; i--) begin
            upper_nz[i] = upper_nz[i+1] | (bcd_disp_q[i*4 +: 4] != 4'd0);
        end
        cursor_act = ((disp_mode_q == 4'd0) || (disp_mode_q == 4'd1) || (disp_mode_q == 4'd5))
                     && (bus.cursor_in <= 3'd2);
        case (scan_idx_q)
            3'd0:    nib = bcd_disp_q[3:0];
            3'd1:    nib = bcd_disp_q[7:4];
            3'd2:    nib = bcd_disp_q[11:8];
            3'd3:    nib = bcd_disp_q[15:12];
            3'd4:    nib = bcd_disp_q[19:16];
            3'd5:    nib = bcd_disp_q[23:20];
            default: nib = 4'd0;
        endcase
        case (disp_mode_q)
            4'd0:    letter = 8'h8E;
            4'd1:    letter = 8'h8C;
            4'd2:    letter = 8'hA1;
            4'd3:    letter = 8'hAF;
            4'd4:    letter = 8'h92;
            4'd5:    letter = 8'h89;
            4'd6:    letter = 8'hC1;
            4'd7:    letter = 8'h88;
            default: letter = 8'hFF;
        endcase
        digit_seg = 8'hFF;
        if (scan_idx_q == 3'd7) begin
            digit_seg = letter;
        end else if (scan_idx_q <= 3'd5) begin
            if (cursor_act && (scan_idx_q == bus.cursor_in)) begin
                digit_seg = blink_on_q ? num_seg(nib) : 8'hFF;
            end else if ((scan_idx_q == 3'd0) || upper_nz[scan_idx_q]) begin
                digit_seg = num_seg(nib);
            end
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= 8'hFF;
        end else begin
            seg_q <= digit_seg;
            an_q  <= ~(8'd1 << scan_idx_q);
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a frame scoreboard.
module tb_seg_display_driver;

    localparam int unsigned ScanDiv  = 3;
    localparam int unsigned BlinkDiv = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_display_if bus_if ();

    seg_display_driver #(
        .SCAN_DIV  (ScanDiv),
        .BLINK_DIV (BlinkDiv)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [63:0] segs;
        int          blink_digit;
        logic [7:0]  blink_seg;
    } frame_t;

    frame_t      sb_q [$];
    int          tests = 0;
    int          fails = 0;
    int unsigned edges;

    logic [7:0] num_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] let_tab [8]  = '{8'h8E, 8'h8C, 8'hA1, 8'hAF, 8'h92, 8'h89, 8'hC1, 8'h88};

    // Clock edges since reset release; edge p outputs reflect counter value p-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t model(input int unsigned value, input int unsigned mode,
                                     input int unsigned cursor);
        frame_t      f;
        int unsigned v;
        int unsigned dig [6];
        int          hi;
        bit          cur;
        v  = (value > 999999) ? 999999 : value;
        hi = -1;
        for (int i = 0; i < 6; i++) begin
            dig[i] = v % 10;
            v      = v / 10;
            if (dig[i] != 0) hi = i;
        end
        cur = ((mode == 0) || (mode == 1) || (mode == 5)) && (cursor <= 2);
        f.segs        = '1;
        f.blink_digit = -1;
        f.blink_seg   = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if ((i == 0) || (i <= hi)) f.segs[i*8 +: 8] = num_tab[dig[i]];
        end
        if (cur) begin
            f.blink_digit = int'(cursor);
            f.blink_seg   = num_tab[dig[cursor]];
        end
        f.segs[63:56] = (mode < 8) ? let_tab[mode] : 8'hFF;
        return f;
    endfunction

    task automatic drive(input int unsigned value, input int unsigned mode,
                         input int unsigned cursor);
        bus_if.display_value = value[19:0];
        bus_if.display_mode  = mode[3:0];
        bus_if.cursor_in     = cursor[2:0];
    endtask

    // Observe one full scan (8 digits) and compare against the oldest queued frame.
    task automatic check_frame(input string tag);
        frame_t     f;
        int         d;
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_empty observed=0 expected=1", tag);
            return;
        end
        f = sb_q.pop_front();
        for (int k = 0; k < 8 * int'(ScanDiv); k++) begin
            @(negedge clk);
            d       = int'(((edges - 1) / ScanDiv) % 8);
            exp_an  = ~(8'd1 << d);
            exp_seg = f.segs[d*8 +: 8];
            if (d == f.blink_digit) begin
                exp_seg = ((((edges - 1) / BlinkDiv) % 2) == 0) ? f.blink_seg : 8'hFF;
            end
            check({tag, "_an"}, {24'd0, bus_if.an}, {24'd0, exp_an});
            check({tag, "_seg"}, {24'd0, bus_if.seg}, {24'd0, exp_seg});
        end
    endtask

    initial begin
        logic [23:0] exp_bcd;
        rst_n = 1'b0;
        drive(0, 0, 7);
        repeat (3) @(negedge clk);
        check("rst_an", {24'd0, bus_if.an}, 32'hFF);
        check("rst_seg", {24'd0, bus_if.seg}, 32'hFF);
        check("rst_bcd", {8'd0, dut.bcd_disp_q}, 32'd0);
        rst_n = 1'b1;

        // Zero after reset: digit 0 shows 0, letter F.
        sb_q.push_back(model(0, 0, 7));
        check_frame("zero");
        sb_q.push_back(model(0, 0, 7));
        check_frame("zero_wrap");

        // Conversion latency: old value through edge 22, new at edge 23.
        drive(123456, 0, 7);
        for (int p = 1; p <= 23; p++) begin
            @(negedge clk);
            exp_bcd = (p < 23) ? 24'h000000 : 24'h123456;
            check($sformatf("lat_p%0d", p), {8'd0, dut.bcd_disp_q}, {8'd0, exp_bcd});
        end
        sb_q.push_back(model(123456, 0, 7));
        check_frame("v123456");

        // Clamp to 999999.
        drive(20'hFFFFF, 0, 7);
        repeat (25) @(negedge clk);
        sb_q.push_back(model(20'hFFFFF, 0, 7));
        check_frame("clamp");

        // Mode without cursor support.
        drive(7, 2, 1);
        repeat (25) @(negedge clk);
        sb_q.push_back(model(7, 2, 1));
        check_frame("mode2");

        // Cursor on digit 1 blinks across frames.
        drive(7, 0, 1);
        repeat (25) @(negedge clk);
        sb_q.push_back(model(7, 0, 1));
        sb_q.push_back(model(7, 0, 1));
        check_frame("blink_a");
        check_frame("blink_b");

        // Cursor index out of range: no cursor effect.
        drive(7, 0, 3);
        repeat (2) @(negedge clk);
        sb_q.push_back(model(7, 0, 3));
        check_frame("cur3");

        // Undefined mode code blanks the annunciator.
        drive(0, 9, 7);
        repeat (25) @(negedge clk);
        sb_q.push_back(model(0, 9, 7));
        check_frame("mode9");

        // Change during conversion: 555 commits first, then 999 twenty-three edges later.
        drive(100, 0, 7);
        repeat (25) @(negedge clk);
        drive(555, 0, 7);
        for (int p = 1; p <= 48; p++) begin
            @(negedge clk);
            exp_bcd = (p < 23) ? 24'h000100 : ((p < 46) ? 24'h000555 : 24'h000999);
            check($sformatf("b2b_p%0d", p), {8'd0, dut.bcd_disp_q}, {8'd0, exp_bcd});
            if (p == 6) drive(999, 0, 7);
        end
        sb_q.push_back(model(999, 0, 7));
        check_frame("v999");

        // Reset mid-conversion returns to reset state with nothing committed.
        drive(4321, 1, 7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_an", {24'd0, bus_if.an}, 32'hFF);
        check("rst2_bcd", {8'd0, dut.bcd_disp_q}, 32'd0);
        drive(0, 0, 7);
        rst_n = 1'b1;
        sb_q.push_back(model(0, 0, 7));
        check_frame("after_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
